// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of instruction-fetch and load/store requests onto one memory bus
//
// Purpose: grants one of two requesters (fetch, data) per bus transaction,
// drives the memory bus for the duration of the transaction, returns read
// data and a one-cycle done pulse, and aborts a transaction that sees no
// mem_ready within TIMEOUT cycles.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   fetch_req, fetch_addr        fetch request (held until fetch_done) and address
//   fetch_done, fetch_rdata      one-cycle completion pulse and fetched word
//   data_req, data_we            load/store request (held until data_done), 1=store
//   data_addr, data_wdata        load/store address and store data
//   data_done, data_rdata        one-cycle completion pulse and load result
//   mem_valid, mem_address       bus transaction active and bus address
//   mem_rw, mem_datao            bus direction (1=read) and write data
//   mem_data, mem_ready          read data and completion from memory
//   err                          transaction timed out, valid with a done pulse

module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_address,
    output logic        mem_rw,
    output logic [31:0] mem_datao,
    input  logic [31:0] mem_data,
    input  logic        mem_ready,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BUSY_CNT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic        last_data;     // 1 when the previous grant went to data
    logic        cur_data;      // requester owning the current transaction
    logic        grant_data;
    logic        any_req;
    logic        timeout_hit;
    logic [7:0]  busy_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rw_q;
    logic        err_q;
    logic [31:0] fetch_rdata_q;
    logic [31:0] data_rdata_q;

    assign any_req     = fetch_req | data_req;
    // On contention the requester that lost last time wins.
    assign grant_data  = data_req & (~fetch_req | ~last_data);
    assign timeout_hit = (busy_cnt == LAST_BUSY_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (mem_ready || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_data     <= 1'b1;
            cur_data      <= 1'b0;
            busy_cnt      <= 8'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            rw_q          <= 1'b1;
            err_q         <= 1'b0;
            fetch_rdata_q <= 32'd0;
            data_rdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_data  <= grant_data;
                        last_data <= grant_data;
                        addr_q    <= grant_data ? data_addr : fetch_addr;
                        wdata_q   <= grant_data ? data_wdata : 32'd0;
                        rw_q      <= grant_data ? ~data_we : 1'b1;
                        busy_cnt  <= 8'd0;
                        err_q     <= 1'b0;
                    end
                end
                BUSY: begin
                    // mem_ready takes priority over a timeout in the same cycle.
                    if (mem_ready) begin
                        err_q <= 1'b0;
                        if (rw_q) begin
                            if (cur_data) data_rdata_q  <= mem_data;
                            else          fetch_rdata_q <= mem_data;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (cur_data) data_rdata_q  <= 32'd0;
                        else          fetch_rdata_q <= 32'd0;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_valid   = (state == BUSY);
    assign mem_address = mem_valid ? addr_q  : 32'd0;
    assign mem_datao   = mem_valid ? wdata_q : 32'd0;
    assign mem_rw      = mem_valid ? rw_q    : 1'b1;

    assign fetch_done  = (state == RESP) & ~cur_data;
    assign data_done   = (state == RESP) &  cur_data;
    assign err         = (state == RESP) &  err_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model

module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        mem_valid;
    logic [31:0] mem_address;
    logic        mem_rw;
    logic [31:0] mem_datao;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who won last, and what each requester should hold.
    bit          m_last_data;
    logic [31:0] m_frd;
    logic [31:0] m_drd;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_done  (fetch_done),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_done   (data_done),
        .data_rdata  (data_rdata),
        .mem_valid   (mem_valid),
        .mem_address (mem_address),
        .mem_rw      (mem_rw),
        .mem_datao   (mem_datao),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .err         (err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        chk1({tag, "_valid"}, mem_valid, 1'b0);
        chk ({tag, "_addr"}, mem_address, 32'd0);
        chk1({tag, "_rw"}, mem_rw, 1'b1);
        chk ({tag, "_datao"}, mem_datao, 32'd0);
        chk1({tag, "_fdone"}, fetch_done, 1'b0);
        chk1({tag, "_ddone"}, data_done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk ({tag, "_frdata"}, fetch_rdata, m_frd);
        chk ({tag, "_drdata"}, data_rdata, m_drd);
    endtask

    // One complete transaction from an idle DUT. delay is the BUSY cycle index
    // (0-based) in which mem_ready is raised; delay >= TO means never.
    task automatic run_txn(input bit fr, input bit dr, input bit we,
                           input logic [31:0] fa, input logic [31:0] da,
                           input logic [31:0] wd, input int delay,
                           input logic [31:0] rd, input bit drop);
        bit          g_data;
        bit          is_read;
        bit          exp_err;
        int          done_idx;
        logic [31:0] exp_addr;

        @(negedge clock);
        fetch_req  = fr;
        data_req   = dr;
        fetch_addr = fa;
        data_addr  = da;
        data_we    = we;
        data_wdata = wd;
        mem_ready  = 1'b0;
        mem_data   = $urandom;

        if (fr && dr) g_data = !m_last_data;
        else          g_data = dr;
        m_last_data = g_data;
        is_read  = !g_data || !we;
        exp_addr = g_data ? da : fa;
        done_idx = (delay < TO) ? delay : TO - 1;
        exp_err  = (delay >= TO);

        for (int b = 0; b <= done_idx; b++) begin
            @(negedge clock);
            chk1("busy_valid", mem_valid, 1'b1);
            chk ("busy_addr", mem_address, exp_addr);
            chk1("busy_rw", mem_rw, is_read);
            if (g_data && we) chk("busy_datao", mem_datao, wd);
            chk1("busy_fdone", fetch_done, 1'b0);
            chk1("busy_ddone", data_done, 1'b0);
            chk1("busy_err", err, 1'b0);
            if (drop && b == 0) begin
                fetch_req = 1'b0;
                data_req  = 1'b0;
            end
            mem_ready = (b == delay);
            mem_data  = (b == delay) ? rd : $urandom;
        end

        if (exp_err) begin
            if (g_data) m_drd = 32'd0;
            else        m_frd = 32'd0;
        end else if (is_read) begin
            if (g_data) m_drd = rd;
            else        m_frd = rd;
        end

        @(negedge clock);
        chk1("resp_valid", mem_valid, 1'b0);
        chk ("resp_addr", mem_address, 32'd0);
        chk1("resp_rw", mem_rw, 1'b1);
        chk1("resp_fdone", fetch_done, !g_data);
        chk1("resp_ddone", data_done, g_data);
        chk1("resp_err", err, exp_err);
        chk ("resp_frdata", fetch_rdata, m_frd);
        chk ("resp_drdata", data_rdata, m_drd);
        fetch_req = 1'b0;
        data_req  = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_data  = $urandom;

        @(negedge clock);
        idle_check("post");
        mem_ready = 1'($urandom_range(0, 1));
        mem_data  = $urandom;
    endtask

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'd0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        mem_data   = 32'd0;
        mem_ready  = 1'b0;
        m_last_data = 1'b1;
        m_frd       = 32'd0;
        m_drd       = 32'd0;

        repeat (3) @(negedge clock);
        idle_check("reset");
        reset = 1'b0;

        // Contention after reset alternates fetch, data, fetch.
        run_txn(1, 1, 0, 32'h0000_1000, 32'h0000_2000, 32'h0, 1, 32'h1111_1111, 0);
        run_txn(1, 1, 0, 32'h0000_1004, 32'h0000_2004, 32'h0, 0, 32'h2222_2222, 0);
        run_txn(1, 1, 1, 32'h0000_1008, 32'h0000_2008, 32'hABCD, 2, 32'h3333_3333, 0);

        // Fetch only with mem_ready two cycles after mem_valid.
        run_txn(1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 2, 32'hDEAD_BEEF, 0);

        // Store: data_rdata must stay unchanged.
        run_txn(0, 1, 1, 32'h0, 32'h0000_0020, 32'h0000_0055, 3, 32'hFFFF_FFFF, 0);

        // Load that times out, then a fetch that times out.
        run_txn(0, 1, 0, 32'h0, 32'h0000_0040, 32'h0, 20, 32'h0, 0);
        run_txn(1, 0, 0, 32'h0000_0044, 32'h0, 32'h0, 9, 32'h0, 0);

        // mem_ready in the very cycle the timeout would fire wins.
        run_txn(0, 1, 0, 32'h0, 32'h0000_0048, 32'h0, TO - 1, 32'hCAFE_F00D, 0);

        // Request dropped during BUSY still completes.
        run_txn(1, 0, 0, 32'h0000_0200, 32'h0, 32'h0, 2, 32'h1234_5678, 1);

        for (int i = 0; i < 40; i++) begin
            bit fr;
            bit dr;
            fr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!fr && !dr) fr = 1'b1;
            run_txn(fr, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 7) == 0));
        end

        // Reset in the second BUSY cycle abandons the transaction.
        @(negedge clock);
        fetch_req  = 1'b1;
        data_req   = 1'b0;
        fetch_addr = 32'h0000_0300;
        mem_ready  = 1'b0;
        @(negedge clock);
        chk1("rst_busy1_valid", mem_valid, 1'b1);
        @(negedge clock);
        chk1("rst_busy2_valid", mem_valid, 1'b1);
        reset     = 1'b1;
        fetch_req = 1'b0;
        @(negedge clock);
        m_last_data = 1'b1;
        m_frd       = 32'd0;
        m_drd       = 32'd0;
        idle_check("rst_mid");
        reset = 1'b0;
        @(negedge clock);
        idle_check("rst_after");

        // First contention after that reset goes to fetch again.
        run_txn(1, 1, 0, 32'h0000_0400, 32'h0000_0500, 32'h0, 1, 32'h5A5A_5A5A, 0);
        run_txn(1, 1, 0, 32'h0000_0404, 32'h0000_0504, 32'h0, 1, 32'hA5A5_A5A5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
